// File: rtl/rsc_encoder.sv
// Turbo-code constituent encoder: recursive systematic convolutional code, K=4.
// Feedback 1+D^2+D^3 (13 oct), feedforward 1+D+D^3 (15 oct). Each input byte becomes one
// {sys[7:0], par[7:0]} word; every frame closes with a 3-bit termination tail word that
// drives the trellis back to state 0.
module rsc_encoder #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [15:0]      o_data,
  output logic             o_tail,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEnc,
    StOut,
    StTail,
    StTout
  } state_e;

  state_e             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         byte_q, byte_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         sys_q, sys_d;
  logic [7:0]         par_q, par_d;
  logic [15:0]        data_q, data_d;

  logic u, a, p;

  // Trellis step shared by data and tail phases; in the tail u is forced so that a = 0.
  always_comb begin
    u = (state_q == StTail) ? (s2_q ^ s3_q) : byte_q[7];
    a = u ^ s2_q ^ s3_q;
    p = a ^ s1_q ^ s3_q;
  end

  // Next-state logic for the FSM, trellis register, counters and output word.
  always_comb begin
    state_d   = state_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    s3_d      = s3_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    bit_cnt_d = bit_cnt_q;
    sys_d     = sys_q;
    par_d     = par_q;
    data_d    = data_q;

    unique case (state_q)
      StIdle: begin
        if (i_start && (i_len != '0)) begin
          s1_d    = 1'b0;
          s2_d    = 1'b0;
          s3_d    = 1'b0;
          cnt_d   = i_len;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (i_valid) begin
          byte_d    = i_data;
          bit_cnt_d = 3'd0;
          state_d   = StEnc;
        end
      end
      StEnc: begin
        s3_d      = s2_q;
        s2_d      = s1_q;
        s1_d      = a;
        byte_d    = {byte_q[6:0], 1'b0};
        sys_d     = {sys_q[6:0], u};
        par_d     = {par_q[6:0], p};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_d  = {sys_q[6:0], u, par_q[6:0], p};
          state_d = StOut;
        end
      end
      StOut: begin
        if (i_ready) begin
          cnt_d     = cnt_q - LEN_W'(1);
          bit_cnt_d = 3'd0;
          state_d   = (cnt_q == LEN_W'(1)) ? StTail : StLoad;
        end
      end
      StTail: begin
        s3_d      = s2_q;
        s2_d      = s1_q;
        s1_d      = a;
        sys_d     = {sys_q[6:0], u};
        par_d     = {par_q[6:0], p};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd2) begin
          data_d  = {sys_q[1:0], u, par_q[1:0], p, 10'b0};
          state_d = StTout;
        end
      end
      StTout: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous abort to IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      byte_q    <= '0;
      bit_cnt_q <= '0;
      sys_q     <= '0;
      par_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      bit_cnt_q <= bit_cnt_d;
      sys_q     <= sys_d;
      par_q     <= par_d;
      data_q    <= data_d;
    end
  end

  // Outputs decode straight from the state so reset clears them immediately.
  always_comb begin
    o_ready = (state_q == StLoad);
    o_valid = (state_q == StOut) || (state_q == StTout);
    o_tail  = (state_q == StTout);
    o_busy  = (state_q != StIdle);
    o_data  = data_q;
  end

endmodule

// File: tb/tb_rsc_encoder.sv
// Directed bench for rsc_encoder: hand-computed words plus a small bit-level trellis model.
module tb_rsc_encoder;

  localparam int unsigned LEN_W = 8;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_valid;
  logic             o_ready;
  logic [7:0]       i_data;
  logic             o_valid;
  logic             i_ready;
  logic [15:0]      o_data;
  logic             o_tail;
  logic             o_busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference trellis state
  logic m1, m2, m3;

  rsc_encoder #(.LEN_W(LEN_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_len   (i_len),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_tail  (o_tail),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [15:0] w);
    logic u, a, p;
    w = '0;
    for (int i = 7; i >= 0; i--) begin
      u = b[i];
      a = u ^ m2 ^ m3;
      p = a ^ m1 ^ m3;
      w[8+i] = u;
      w[i]   = p;
      m3 = m2;
      m2 = m1;
      m1 = a;
    end
  endtask

  task automatic model_tail(output logic [15:0] w);
    logic u, a, p;
    w = '0;
    for (int k = 0; k < 3; k++) begin
      u = m2 ^ m3;
      a = u ^ m2 ^ m3;
      p = a ^ m1 ^ m3;
      w[15-k] = u;
      w[12-k] = p;
      m3 = m2;
      m2 = m1;
      m1 = a;
    end
  endtask

  // All tasks below start and end at a falling edge.
  task automatic start_frame(input logic [LEN_W-1:0] len);
    i_start = 1'b1;
    i_len   = len;
    @(negedge i_clk);
    i_start = 1'b0;
    m1 = 1'b0;
    m2 = 1'b0;
    m3 = 1'b0;
  endtask

  task automatic push_byte(input string tag, input logic [7:0] b);
    bit done;
    done    = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (o_ready) done = 1'b1;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    if (!done) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic get_word(input string tag, input logic [15:0] exp_data, input logic exp_tail);
    bit found;
    found   = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50 && !found; k++) begin
      if (o_valid) found = 1'b1;
      else @(negedge i_clk);
    end
    if (found) begin
      check({tag, "_data"}, 32'(o_data), 32'(exp_data));
      check({tag, "_tail"}, 32'(o_tail), 32'(exp_tail));
      @(negedge i_clk);
      check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    end else begin
      check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    end
    i_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] w;
    logic [15:0] words [4];
    logic        tails [4];
    int          times [4];
    logic [7:0]  bytes3 [3];
    int          nw, bi;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_tail",  32'(o_tail),  32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 1. Reset in the middle of ENC, then a clean frame
    start_frame(8'd1);
    push_byte("t1_push", 8'hA5);
    repeat (3) @(negedge i_clk);
    check("t1_busy_enc", 32'(o_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(o_valid), 32'd0);
    check("t1_async_ready", 32'(o_ready), 32'd0);
    check("t1_async_busy",  32'(o_busy),  32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    start_frame(8'd1);
    push_byte("t1b_push", 8'hA5);
    model_byte(8'hA5, w);
    get_word("t1b_word", w, 1'b0);
    model_tail(w);
    get_word("t1b_tailw", w, 1'b1);
    check("t1b_idle", 32'(o_busy), 32'd0);

    // 2. len=1, 0x80
    start_frame(8'd1);
    push_byte("t2_push", 8'h80);
    get_word("t2_word", 16'h80F2, 1'b0);
    get_word("t2_tailw", 16'h7400, 1'b1);
    check("t2_idle", 32'(o_busy), 32'd0);

    // 3. len=1, 0x00
    start_frame(8'd1);
    push_byte("t3_push", 8'h00);
    get_word("t3_word", 16'h0000, 1'b0);
    get_word("t3_tailw", 16'h0000, 1'b1);
    check("t3_idle", 32'(o_busy), 32'd0);

    // 4. len=3 streaming with i_valid and i_ready held high
    bytes3[0] = 8'h80;
    bytes3[1] = 8'h00;
    bytes3[2] = 8'h00;
    start_frame(8'd3);
    nw = 0;
    bi = 0;
    i_valid = 1'b1;
    i_data  = bytes3[0];
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && nw < 4; cyc++) begin
      if (o_valid) begin
        words[nw] = o_data;
        tails[nw] = o_tail;
        times[nw] = cyc;
        nw++;
      end
      if (o_ready && bi < 3) bi++;
      @(posedge i_clk);
      #1;
      if (bi < 3) i_data = bytes3[bi];
      else i_valid = 1'b0;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    check("t4_nwords", 32'(nw), 32'd4);
    check("t4_busy_end", 32'(o_busy), 32'd0);
    i_ready = 1'b0;
    if (nw == 4) begin
      check("t4_gap01", 32'(times[1] - times[0]), 32'd10);
      check("t4_gap12", 32'(times[2] - times[1]), 32'd10);
      check("t4_w0_const", 32'(words[0]), 32'h80F2);
      for (int i = 0; i < 3; i++) begin
        model_byte(bytes3[i], w);
        check($sformatf("t4_w%0d", i), 32'(words[i]), 32'(w));
        check($sformatf("t4_t%0d", i), 32'(tails[i]), 32'd0);
      end
      model_tail(w);
      check("t4_tailw", 32'(words[3]), 32'(w));
      check("t4_tailflag", 32'(tails[3]), 32'd1);
      check("t4_model_state0", 32'({m1, m2, m3}), 32'd0);
    end

    // 5. Backpressure in OUT for 20 cycles
    start_frame(8'd1);
    push_byte("t5_push", 8'h80);
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_clk);
    for (int k = 0; k < 20; k++) begin
      check("t5_hold_data",  32'(o_data),  32'h80F2);
      check("t5_hold_valid", 32'(o_valid), 32'd1);
      check("t5_hold_ready", 32'(o_ready), 32'd0);
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    check("t5_released", 32'(o_valid), 32'd0);
    check("t5_load", 32'(o_ready), 32'd0);
    i_ready = 1'b0;
    get_word("t5_tailw", 16'h7400, 1'b1);

    // 6. Zero-length start is ignored; start mid-frame is ignored
    i_start = 1'b1;
    i_len   = 8'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    check("t6_len0_busy", 32'(o_busy), 32'd0);
    check("t6_len0_ready", 32'(o_ready), 32'd0);
    start_frame(8'd1);
    push_byte("t6_push", 8'h3C);
    i_start = 1'b1;
    i_len   = 8'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    model_byte(8'h3C, w);
    get_word("t6_word", w, 1'b0);
    model_tail(w);
    get_word("t6_tailw", w, 1'b1);
    check("t6_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
